aes_round_sched: RTL

Round sequencer for the AES-128 encryption datapath. Accepts a 128-bit plaintext block and steps it through the initial AddRoundKey, rounds 1–9 and the final round 10. Each round fetches its key from an external key-schedule unit through a request/valid handshake. The combinational SubBytes+MixColumns unit computes rounds 1–9; a SubBytes-only unit computes round 10; this block applies ShiftRows and AddRoundKey and holds the state register.

---
 rtl/aes_round_sched_if.sv | 29 ++
 rtl/aes_round_sched.sv | 131 +++++++++++++
 2 files changed

// File: rtl/aes_round_sched_if.sv
// rtl/aes_round_sched_if.sv - block, round-key and datapath signals of aes_round_sched
interface aes_round_sched_if;
  logic         in_vld;
  logic         in_rdy;
  logic [127:0] in_data;
  logic         out_vld;
  logic         out_rdy;
  logic [127:0] out_data;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_vld;
  logic [127:0] rk_data;
  logic [127:0] mcsb_in;
  logic [127:0] mcsb_out;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic         busy;
  logic [3:0]   rnd;

  modport slave (
    input  in_vld, in_data, out_rdy, rk_vld, rk_data, mcsb_out, sb_out,
    output in_rdy, out_vld, out_data, rk_req, rk_idx, mcsb_in, sb_in, busy, rnd
  );

  modport master (
    output in_vld, in_data, out_rdy, rk_vld, rk_data, mcsb_out, sb_out,
    input  in_rdy, out_vld, out_data, rk_req, rk_idx, mcsb_in, sb_in, busy, rnd
  );
endinterface

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - AES-128 round sequencer: state register, ShiftRows, AddRoundKey
// Optional pipeline register before AddRoundKey: define AES_ROUND_REG_EN.
module aes_round_sched (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    KEY,
`ifdef AES_ROUND_REG_EN
    EXEC,
`endif
    DONE
  } st_t;

  st_t          st, st_nxt;
  logic [127:0] state, state_nxt;
  logic [3:0]   rnd_cnt, rnd_cnt_nxt;
  logic [127:0] sr;
  logic [127:0] rnd_res;
  logic         req;
`ifdef AES_ROUND_REG_EN
  logic [127:0] pipe, pipe_nxt;
`endif

  // Byte (row r, column c) sits at bits [127-8*(r+4c) -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
      end
    end
    return r;
  endfunction

  assign sr      = shift_rows(state);
  assign rnd_res = (rnd_cnt == 4'd10) ? bus.sb_out : bus.mcsb_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= IDLE;
      state   <= '0;
      rnd_cnt <= '0;
`ifdef AES_ROUND_REG_EN
      pipe    <= '0;
`endif
    end else begin
      st      <= st_nxt;
      state   <= state_nxt;
      rnd_cnt <= rnd_cnt_nxt;
`ifdef AES_ROUND_REG_EN
      pipe    <= pipe_nxt;
`endif
    end
  end

  always_comb begin
    st_nxt      = st;
    state_nxt   = state;
    rnd_cnt_nxt = rnd_cnt;
`ifdef AES_ROUND_REG_EN
    pipe_nxt    = pipe;
`endif
    case (st)
      IDLE: begin
        if (bus.in_vld) begin
          state_nxt   = bus.in_data;
          rnd_cnt_nxt = 4'd0;
          st_nxt      = KEY;
        end
      end
      KEY: begin
`ifdef AES_ROUND_REG_EN
        if (rnd_cnt != 4'd0) begin
          pipe_nxt = rnd_res;
          st_nxt   = EXEC;
        end else if (bus.rk_vld) begin
          state_nxt   = state ^ bus.rk_data;
          rnd_cnt_nxt = 4'd1;
        end
`else
        if (bus.rk_vld) begin
          state_nxt = ((rnd_cnt == 4'd0) ? state : rnd_res) ^ bus.rk_data;
          // Round 10 is the last one; the counter parks there instead of wrapping.
          if (rnd_cnt == 4'd10) st_nxt = DONE;
          else                  rnd_cnt_nxt = rnd_cnt + 4'd1;
        end
`endif
      end
`ifdef AES_ROUND_REG_EN
      EXEC: begin
        if (bus.rk_vld) begin
          state_nxt = pipe ^ bus.rk_data;
          if (rnd_cnt == 4'd10) begin
            st_nxt = DONE;
          end else begin
            rnd_cnt_nxt = rnd_cnt + 4'd1;
            st_nxt      = KEY;
          end
        end
      end
`endif
      DONE: begin
        if (bus.out_rdy) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

`ifdef AES_ROUND_REG_EN
  assign req = (st == KEY) || (st == EXEC);
`else
  assign req = (st == KEY);
`endif

  assign bus.in_rdy   = (st == IDLE);
  assign bus.busy     = (st != IDLE);
  assign bus.out_vld  = (st == DONE);
  assign bus.out_data = (st == DONE) ? state : '0;
  assign bus.rk_req   = req;
  // Gated so the index only moves on the edge that consumes a key.
  assign bus.rk_idx   = req ? rnd_cnt : 4'd0;
  assign bus.mcsb_in  = sr;
  assign bus.sb_in    = sr;
  assign bus.rnd      = rnd_cnt;

endmodule
